// File: rtl/aes_pkg.sv
// AES byte-substitution tables and byte-position helpers shared by the
// iterative SubBytes engine and its per-lane S-box.
package aes_pkg;

  // Entry i lives at bits [2047-8i -: 8]; rows follow the textbook 16x16 layout.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
    int idx;
    idx = 2040 - 8 * int'(b);
    return inv ? SBOX_INV[idx +: 8] : SBOX_FWD[idx +: 8];
  endfunction

  // LSB position of state byte k; byte 0 is the most significant byte.
  function automatic int byte_lsb(input int k);
    return 120 - 8 * k;
  endfunction

endpackage

// File: rtl/aes_sbox_fi.sv
// Combinational forward/inverse AES S-box for one byte lane.
module aes_sbox_fi
  import aes_pkg::*;
(
  input  logic [7:0] a,
  input  logic       inv,
  output logic [7:0] s
);

  assign s = sbox_lookup(a, inv);

endmodule

// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes/InvSubBytes: LANES bytes substituted per cycle,
// a full 128-bit state every 16/LANES cycles, valid/ready on both sides.
module subbytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NPASS = 16 / LANES;
  localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("subbytes_iter: LANES must be one of 1, 2, 4, 8, 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    mode;
  logic [127:0]            st;
  logic [LANES-1:0][7:0]   lane_in;
  logic [LANES-1:0][7:0]   lane_out;

  assign out_data = st;

  // Lane l works on byte cnt*LANES + l of the current pass.
  always_comb begin
    lane_in = '0;
    for (int l = 0; l < LANES; l++)
      lane_in[l] = st[byte_lsb(int'(cnt) * LANES + l) +: 8];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_fi u_sbox (
      .a   (lane_in[l]),
      .inv (mode),
      .s   (lane_out[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      st        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          st       <= in_data;
          mode     <= in_inv;
          cnt      <= '0;
          state    <= RUN;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          for (int l = 0; l < LANES; l++)
            st[byte_lsb(int'(cnt) * LANES + l) +: 8] <= lane_out[l];
          // Last pass holds cnt rather than wrapping; it is cleared on the next accept.
          if (cnt == CW'(NPASS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subbytes_iter.sv
// Scoreboard bench for subbytes_iter: directed vectors, backpressure, reset
// abort and random traffic against a GF(2^8)-derived reference S-box.
module tb_subbytes_iter;

  localparam int LANES = 4;
  localparam int NPASS = 16 / LANES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_inv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         busy;

  subbytes_iter #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct { logic [127:0] data; int acc; } exp_t;
  exp_t exp_q[$];

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S(x) = affine(x^-1) over GF(2^8); the inverse table is its preimage map.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] y, s;
      y = '0;
      if (x != 0)
        for (int c = 1; c < 256; c++)
          if (gf_mul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
      s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
      fwd_t[x] = s;
      inv_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
    logic [127:0] r = '0;
    for (int k = 0; k < 16; k++)
      r[127 - 8*k -: 8] = inv ? inv_t[d[127 - 8*k -: 8]] : fwd_t[d[127 - 8*k -: 8]];
    return r;
  endfunction

  // Accept side: record expected result at each accept; reset discards pending work.
  always @(posedge clk) begin
    cyc++;
    if (rst) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back('{model(in_data, in_inv), cyc});
  end

  // Output side: compare on out_valid rise, then verify it holds until taken.
  exp_t cur;
  bit   have_cur = 0;
  always @(negedge clk) begin
    if (rst || !out_valid) have_cur = 0;
    else if (!have_cur) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out: got %h expected no output", out_data);
      end else begin
        cur = exp_q.pop_front();
        have_cur = 1;
        chk("latency", 128'(cyc - cur.acc), 128'(NPASS));
        chk("data", out_data, cur.data);
      end
    end else chk("hold", out_data, cur.data);
  end

  bit rnd_ready = 0;

  task automatic send(input logic [127:0] d, input logic inv, output int w);
    bit acc = 0;
    w = 0;
    in_valid = 1'b1; in_data = d; in_inv = inv;
    while (!acc && w < 200) begin
      @(posedge clk);
      w++;
      acc = in_ready;
      if (!acc) begin
        @(negedge clk);
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    if (!acc) begin checks++; failures++; $display("FAIL accept_timeout: got no accept expected accept"); end
    @(negedge clk);
    in_valid = 1'b0;
    in_inv   = ~inv;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      in_inv = 1'($urandom);
      n++;
    end
  endtask

  initial begin
    int w, n;
    build_tables();
    in_valid = 1'b1;  // reset must override a pending request
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_data", out_data, 128'h0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    send(128'h00112233445566778899aabbccddeeff, 1'b0, w);
    wait_out(n);
    chk("fwd_latency", 128'(n), 128'(NPASS));
    chk("fwd_vector", out_data, 128'h638293c31bfc33f5c4eeacea4bc12816);
    chk("busy_done", 128'(busy), 128'(1));
    @(negedge clk);

    send(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, w);
    wait_out(n);
    chk("inv_vector", out_data, 128'h00112233445566778899aabbccddeeff);
    @(negedge clk);

    // Backpressure: result held, second request ignored until handshake.
    out_ready = 1'b0;
    send(128'h00112233445566778899aabbccddeeff, 1'b0, w);
    wait_out(n);
    in_valid = 1'b1; in_data = 128'h638293c31bfc33f5c4eeacea4bc12816; in_inv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_out_data", out_data, 128'h638293c31bfc33f5c4eeacea4bc12816);
    end
    out_ready = 1'b1;
    send(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, w);
    chk("bp_accept_wait", 128'(w), 128'(2));
    wait_out(n);
    chk("bp_second", out_data, 128'h00112233445566778899aabbccddeeff);
    @(negedge clk);

    // Reset abort two cycles into RUN.
    send({16{8'h12}}, 1'b0, w);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    send({16{8'h53}}, 1'b0, w);
    wait_out(n);
    chk("after_abort", out_data, {16{8'hed}});
    @(negedge clk);

    // Random traffic with random backpressure and in_inv noise.
    rnd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), w);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rnd_ready = 0;
    out_ready = 1'b1;
    n = 0;
    while (!(exp_q.size() == 0 && in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    chk("drain_idle", 128'(in_ready), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subbytes_iter.md
SUBBYTES_ITER -- requirements
Module: subbytes_iter

Interface
REQ-001 Parameter LANES, default 4: S-boxes instantiated, i.e. bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 Derived constant NPASS = 16/LANES: cycles per 128-bit state.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  in_data/in_inv valid.
REQ-006 in_ready  output  1  block can accept a new state.
REQ-007 in_data  input  128  AES state; byte k = in_data[127-8k -: 8], k = 0..15.
REQ-008 in_inv  input  1  mode: 0 = forward SubBytes, 1 = InvSubBytes.
REQ-009 out_valid  output  1  out_data holds a completed result.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_data  output  128  substituted state, same byte order as in_data.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-014 IDLE: on in_valid && in_ready the block SHALL load in_data into the state register, latch in_inv into a mode register, clear pass counter cnt, and go to RUN.
REQ-015 in_inv SHALL be sampled only on the accept edge; changes on in_inv during RUN/DONE SHALL have no effect.
REQ-016 RUN: on each edge, bytes k = cnt*LANES .. cnt*LANES+LANES-1 SHALL be replaced by S(byte) or S^-1(byte) per the mode register, and cnt SHALL increment.
REQ-017 When cnt == NPASS-1 in RUN, the FSM SHALL go to DONE on that edge; cnt width is max(1, clog2(NPASS)) and cnt never wraps inside a block.
REQ-018 Each of the 16 bytes SHALL be substituted exactly once per block; no byte is skipped or duplicated.
REQ-019 Latency: out_valid SHALL rise exactly NPASS cycles after the accept edge (LANES=4: 4 cycles; LANES=16: 1 cycle).
REQ-020 DONE: out_data SHALL be held stable while out_valid && !out_ready; on out_ready the FSM SHALL return to IDLE.
REQ-021 in_ready SHALL be low in RUN and DONE; in_valid there SHALL be ignored, with no buffering.
REQ-022 Minimum spacing between accepts with out_ready tied high SHALL be NPASS+2 cycles.
REQ-023 out_data SHALL always drive the state register; it is meaningful only while out_valid is high.

Reset
REQ-024 On rst the block SHALL go to IDLE, with cnt = 0, mode = 0, state register = 128'h0, out_valid = 0, in_ready = 1 and busy = 0 on the following cycle.
REQ-025 rst asserted in RUN or DONE SHALL abort the block with no output; a pending result SHALL be discarded.
REQ-026 rst SHALL override a simultaneous in_valid or out_ready.

Structure
REQ-027 A shared package aes_pkg SHALL hold the forward and inverse S-box tables and the byte-index helper; subbytes_iter and the S-box sub-module SHALL import it.
REQ-028 One sub-module, aes_sbox_fi (8-bit in, inv select, 8-bit out, combinational), SHALL be instantiated LANES times via generate.
REQ-029 A LANES value outside {1,2,4,8,16} SHALL cause an elaboration-time error.

Verification
REQ-030 LANES=4, forward, in_data=128'h00112233445566778899aabbccddeeff -> out_data=128'h638293c31bfc33f5c4eeacea4bc12816, out_valid exactly 4 cycles after accept.
REQ-031 LANES=4, inverse, in_data=128'h638293c31bfc33f5c4eeacea4bc12816 -> out_data=128'h00112233445566778899aabbccddeeff.
REQ-032 LANES in {1,2,8,16}, same vectors -> identical results, latency 16/8/2/1 cycles.
REQ-033 Backpressure: out_ready held low 10 cycles -> out_data stable, in_ready low, a second in_valid ignored; it is accepted only after the out_ready handshake.
REQ-034 rst pulsed at RUN cycle 2 -> next cycle IDLE, in_ready=1, out_valid=0; the next block (in_data all 8'h53, forward) -> out_data all 8'hED.
REQ-035 in_inv toggled during RUN -> result matches the mode latched at accept; random back-to-back blocks are checked against a reference model.
